norestore_div_arbiter: RTL and testbench
========================================

// Module: norestore_div_arbiter
// PURPOSE
//  Shares one pipelined non-restoring divider between NREQ requesters. Each
//  cycle it round-robin grants one valid request, registers its operands into
//  the divider and carries a tag (requester id, divide-by-zero flag) alongside.
//  It returns each quotient/remainder to the issuing requester, in issue order.
//  Sits between client blocks and the external divider instance.
// PARAMETERS
//  WIDTH    4          divisor/remainder width; dividend/quotient are 2*WIDTH
//  NREQ     4          number of requesters (>=2)
//  LATENCY  2*WIDTH    divider latency: operands at div_* inputs -> valid div_quotient/div_remainder (edges)
// PORTS
//  clk            in   1             clock
//  rst_n          in   1             asynchronous reset, active low
//  req_valid      in   NREQ          request valid, one bit per requester
//  req_ready      out  NREQ          grant; request i accepted on edge where valid[i]&ready[i]
//  req_dividend   in   NREQ*2*WIDTH  packed dividends, requester i at [i*2W +: 2W]
//  req_divisor    in   NREQ*WIDTH    packed divisors, requester i at [i*W +: W]
//  div_dividend   out  2*WIDTH       registered operand to divider
//  div_divisor    out  WIDTH         registered operand to divider (1 when dbz)
//  div_quotient   in   2*WIDTH       divider quotient, LATENCY edges after operands
//  div_remainder  in   WIDTH         divider corrected remainder
//  rsp_valid      out  NREQ          one-hot response strobe, one cycle
//  rsp_quotient   out  2*WIDTH       response quotient (shared bus)
//  rsp_remainder  out  WIDTH         response remainder (shared bus)
//  rsp_dbz        out  1             response was divide-by-zero
//  busy           out  1             any operation in flight
// BEHAVIOUR
//  Reset: req_ready combinational but 0 while rst_n low; all other outputs 0.
//   Also cleared: rr pointer=0, tag pipeline, div_*.
//  Arbitration: comb. grant = first valid index at or after ptr (wrap mod NREQ).
//   Exactly one req_ready bit set, only if that requester is valid; else none.
//   Pointer <- grant+1 (mod NREQ) on a grant; holds when no request.
//   req_ready depends only on req_valid and ptr, never on responses.
//   No backpressure on responses.
//  Issue (edge t, accepted): div_dividend<=dividend; div_divisor<=divisor, or
//   1 if divisor==0. Tag stage0 <= {v=1,id,dbz,dividend[W-1:0]}. No accept:
//   div_* hold value; tag v=0.
//  Tag pipeline: LATENCY+1 stages, shift every cycle, never stalls.
//   Output stage aligns with div_quotient for the same operation.
//  Response (edge t+LATENCY+1): rsp_valid <= onehot(id) if v else 0.
//   rsp_quotient <= dbz ? all-ones : div_quotient.
//   rsp_remainder <= dbz ? saved dividend[W-1:0] : div_remainder.
//   rsp_dbz <= dbz. Bus holds last value when no response.
//   Total latency accept -> rsp_valid high: LATENCY+2 edges.
//  Throughput: one accept per cycle; responses keep accept order and spacing.
//  Widths: divisor!=0 -> quotient fits 2W, remainder < divisor; no saturation.
//  busy = OR of tag valids and rsp_valid.
//  Reset mid-operation: in-flight tags dropped; no response ever for them.
//   Divider outputs ignored until new tags arrive.
//  Requester may deassert valid anytime; unaccepted requests are not latched.
// TESTING (WIDTH=4, NREQ=4, LATENCY=8)
//  1 req0 100/7 alone -> req_ready[0] same cycle.
//    rsp_valid=4'b0001 10 edges later; q=14 r=2 dbz=0.
//  2 all four valid 8 cycles -> grants 0,1,2,3,0,1,2,3.
//    rsp_valid one-hot in same order, back-to-back.
//  3 ptr=3 after grant to 2; only req0 and req3 valid -> req3 granted,
//    then req0 next cycle.
//  4 req1 dividend 0xA5, divisor 0 -> rsp_valid[1], q=0xFF r=5 dbz=1.
//    Neighbouring normal ops unaffected.
//  5 req2 255/15 and 255/1 on back-to-back cycles -> q=17 r=0, then q=255 r=0.
//  6 accept 3 ops, pulse rst_n low 5 cycles after -> no rsp_valid for them.
//    busy=0; new op after reset returns correctly.

Source files
------------

// File: rtl/norestore_div_arbiter_if.sv
// Requester-side bundle for the shared divider arbiter.
// Clients drive requests and observe grants and the shared response bus.
interface norestore_div_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*2*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0]   req_divisor;
    logic [NREQ-1:0]         rsp_valid;
    logic [2*WIDTH-1:0]      rsp_quotient;
    logic [WIDTH-1:0]        rsp_remainder;
    logic                    rsp_dbz;

    modport master (
        output req_valid, req_dividend, req_divisor,
        input  req_ready, rsp_valid, rsp_quotient,
        input  rsp_remainder, rsp_dbz
    );

    modport slave (
        input  req_valid, req_dividend, req_divisor,
        output req_ready, rsp_valid, rsp_quotient,
        output rsp_remainder, rsp_dbz
    );
endinterface

// File: rtl/norestore_div_arbiter.sv
// Round-robin arbiter sharing one pipelined divider among NREQ clients.
// A tag pipeline tracks each operation so results return to the issuer.
module norestore_div_arbiter #(
    parameter int WIDTH   = 4,
    parameter int NREQ    = 4,
    parameter int LATENCY = 2*WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    norestore_div_arbiter_if.slave cl,
    output logic [2*WIDTH-1:0]    div_dividend,
    output logic [WIDTH-1:0]      div_divisor,
    input  logic [2*WIDTH-1:0]    div_quotient,
    input  logic [WIDTH-1:0]      div_remainder,
    output logic                  busy
);
    localparam int DW  = 2*WIDTH;
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IDW:0]   NREQ_W = (IDW+1)'(NREQ);
    localparam logic [IDW-1:0] LAST   = IDW'(NREQ-1);

    typedef struct packed {
        logic             v;
        logic [IDW-1:0]   id;
        logic             dbz;
        logic [WIDTH-1:0] lo;
    } tag_t;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [DW-1:0]    div_dividend_q, div_dividend_d;
    logic [WIDTH-1:0] div_divisor_q, div_divisor_d;
    tag_t             tag_q [LATENCY+1];
    tag_t             tag_d [LATENCY+1];
    logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]    rsp_quotient_q, rsp_quotient_d;
    logic [WIDTH-1:0] rsp_remainder_q, rsp_remainder_d;
    logic             rsp_dbz_q, rsp_dbz_d;

    logic             found;
    logic [IDW-1:0]   gnt_id;
    logic [IDW:0]     j;
    logic [NREQ-1:0]  ready_c;
    logic [DW-1:0]    sel_dividend;
    logic [WIDTH-1:0] sel_divisor;
    logic             sel_dbz;
    tag_t             out_tag;
    logic             busy_c;

    // First valid requester at or after the pointer, wrapping mod NREQ.
    always_comb begin
        found  = 1'b0;
        gnt_id = '0;
        j      = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = {1'b0, ptr_q} + (IDW+1)'(k);
            if (j >= NREQ_W) j = j - NREQ_W;
            if (!found && cl.req_valid[j[IDW-1:0]]) begin
                found  = 1'b1;
                gnt_id = j[IDW-1:0];
            end
        end
    end

    always_comb begin
        ready_c = '0;
        if (found && rst_n) ready_c[gnt_id] = 1'b1;
    end

    assign sel_dividend = cl.req_dividend[int'(gnt_id)*DW +: DW];
    assign sel_divisor  = cl.req_divisor[int'(gnt_id)*WIDTH +: WIDTH];
    assign sel_dbz      = (sel_divisor == '0);

    always_comb begin
        ptr_d          = ptr_q;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        tag_d[0]       = '0;
        if (found) begin
            ptr_d          = (gnt_id == LAST) ? '0 : gnt_id + IDW'(1);
            div_dividend_d = sel_dividend;
            div_divisor_d  = sel_dbz ? WIDTH'(1) : sel_divisor;
            tag_d[0].v     = 1'b1;
            tag_d[0].id    = gnt_id;
            tag_d[0].dbz   = sel_dbz;
            tag_d[0].lo    = sel_dividend[WIDTH-1:0];
        end
        for (int k = 1; k <= LATENCY; k++) tag_d[k] = tag_q[k-1];
    end

    // Last tag stage lines up with div_quotient of the same operation.
    assign out_tag = tag_q[LATENCY];

    always_comb begin
        rsp_valid_d     = '0;
        rsp_quotient_d  = rsp_quotient_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_dbz_d       = rsp_dbz_q;
        if (out_tag.v) begin
            rsp_valid_d[out_tag.id] = 1'b1;
            rsp_quotient_d  = out_tag.dbz ? '1 : div_quotient;
            rsp_remainder_d = out_tag.dbz ? out_tag.lo : div_remainder;
            rsp_dbz_d       = out_tag.dbz;
        end
    end

    always_comb begin
        busy_c = |rsp_valid_q;
        for (int k = 0; k <= LATENCY; k++) busy_c = busy_c | tag_q[k].v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q           <= '0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            rsp_valid_q     <= '0;
            rsp_quotient_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dbz_q       <= 1'b0;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= '0;
        end else begin
            ptr_q           <= ptr_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_quotient_q  <= rsp_quotient_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_dbz_q       <= rsp_dbz_d;
            for (int k = 0; k <= LATENCY; k++) tag_q[k] <= tag_d[k];
        end
    end

    assign cl.req_ready     = ready_c;
    assign cl.rsp_valid     = rsp_valid_q;
    assign cl.rsp_quotient  = rsp_quotient_q;
    assign cl.rsp_remainder = rsp_remainder_q;
    assign cl.rsp_dbz       = rsp_dbz_q;
    assign div_dividend     = div_dividend_q;
    assign div_divisor      = div_divisor_q;
    assign busy             = busy_c;
endmodule

// File: tb/tb_norestore_div_arbiter.sv
// Bench for norestore_div_arbiter: emulated external divider plus a
// queue-based reference model of arbitration and response ordering.
module tb_norestore_div_arbiter;
    localparam int W = 4;
    localparam int N = 4;
    localparam int L = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] div_dividend;
    logic [3:0] div_divisor;
    logic [7:0] div_quotient;
    logic [3:0] div_remainder;
    logic       busy;

    norestore_div_arbiter_if #(.WIDTH(W), .NREQ(N)) cl ();

    norestore_div_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cl            (cl),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_remainder (div_remainder),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // External divider: L-edge pipeline of ideal results.
    logic [7:0] dq_pipe [L];
    logic [3:0] dr_pipe [L];
    initial begin
        for (int k = 0; k < L; k++) begin
            dq_pipe[k] = '0;
            dr_pipe[k] = '0;
        end
    end
    always @(posedge clk) begin
        dq_pipe[0] <= (div_divisor == 0) ? 8'hFF : div_dividend / {4'd0, div_divisor};
        dr_pipe[0] <= (div_divisor == 0) ? 4'h0 : 4'(div_dividend % {4'd0, div_divisor});
        for (int k = 1; k < L; k++) begin
            dq_pipe[k] <= dq_pipe[k-1];
            dr_pipe[k] <= dr_pipe[k-1];
        end
    end
    assign div_quotient  = dq_pipe[L-1];
    assign div_remainder = dr_pipe[L-1];

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    typedef struct {
        int         due;
        int         id;
        logic [7:0] q;
        logic [3:0] r;
        logic       dbz;
    } exp_t;

    exp_t       sb[$];
    int         ptr = 0;
    logic [7:0] last_q = '0;
    logic [3:0] last_r = '0;
    logic       last_dbz = 1'b0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic check_rsp();
        logic [3:0] exp_v;
        exp_t e;
        exp_v = '0;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            e = sb.pop_front();
            exp_v = 4'(1 << e.id);
            last_q = e.q;
            last_r = e.r;
            last_dbz = e.dbz;
        end
        chk("rsp_valid", 32'(cl.rsp_valid), 32'(exp_v));
        chk("rsp_quotient", 32'(cl.rsp_quotient), 32'(last_q));
        chk("rsp_remainder", 32'(cl.rsp_remainder), 32'(last_r));
        chk("rsp_dbz", 32'(cl.rsp_dbz), 32'(last_dbz));
        chk("busy", 32'(busy), 32'((exp_v != 0) || (sb.size() > 0)));
    endtask

    task automatic cycle(input logic [3:0] v, input logic [31:0] dvd, input logic [15:0] dvs);
        int g;
        int jj;
        exp_t e;
        logic [7:0] a;
        logic [3:0] b;
        @(negedge clk);
        cl.req_valid = v;
        cl.req_dividend = dvd;
        cl.req_divisor = dvs;
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            jj = (ptr + k) % N;
            if (g < 0 && v[jj]) g = jj;
        end
        chk("req_ready", 32'(cl.req_ready), (g >= 0) ? 32'(1 << g) : 32'd0);
        if (g >= 0) begin
            a = dvd[g*8 +: 8];
            b = dvs[g*4 +: 4];
            e.due = edge_n + 1 + L + 1;
            e.id = g;
            e.dbz = (b == 0);
            e.q = (b == 0) ? 8'hFF : a / {4'd0, b};
            e.r = (b == 0) ? a[3:0] : 4'(a % {4'd0, b});
            sb.push_back(e);
            ptr = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        check_rsp();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(4'b0000, '0, '0);
    endtask

    task automatic rst_pulse(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        cl.req_valid = 4'hF;
        cl.req_divisor = 16'h1111;
        #1;
        chk("rst_ready", 32'(cl.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(cl.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_quotient", 32'(cl.rsp_quotient), 32'd0);
        chk("rst_div_dividend", 32'(div_dividend), 32'd0);
        sb.delete();
        ptr = 0;
        last_q = '0;
        last_r = '0;
        last_dbz = 1'b0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cl.req_valid = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cl.req_valid = '0;
        cl.req_dividend = '0;
        cl.req_divisor = '0;
        rst_pulse(3);

        // Single request, 100/7 on requester 0.
        cycle(4'b0001, {24'd0, 8'd100}, {12'd0, 4'd7});
        idle(12);

        // All four contending for eight cycles.
        for (int k = 0; k < 8; k++)
            cycle(4'hF, $urandom, 16'h7531 + 16'(k) * 16'h1111);
        idle(12);

        // Pointer wrap: grant 2, then 3 and 0 contend.
        cycle(4'b0100, 32'h00C8_0000, 16'h0300);
        cycle(4'b1001, 32'hF000_0011, 16'h5004);
        cycle(4'b1001, 32'hF000_0011, 16'h5004);
        idle(12);

        // Divide by zero on requester 1 between normal ops.
        cycle(4'b0010, 32'h0000_A500, 16'h0000);
        cycle(4'b0111, 32'h0033_A522, 16'h0203);
        cycle(4'b0111, 32'h0033_A522, 16'h0203);
        cycle(4'b0111, 32'h0033_A522, 16'h0203);
        idle(12);

        // Back-to-back on requester 2.
        cycle(4'b0100, 32'h00FF_0000, 16'h0F00);
        cycle(4'b0100, 32'h00FF_0000, 16'h0100);
        idle(12);

        // Reset with operations in flight.
        cycle(4'b0111, 32'h0064_5040, 16'h0753);
        cycle(4'b0111, 32'h0064_5040, 16'h0753);
        cycle(4'b0111, 32'h0064_5040, 16'h0753);
        idle(5);
        rst_pulse(2);
        idle(14);
        cycle(4'b0001, {24'd0, 8'd100}, {12'd0, 4'd7});
        idle(12);

        // Randomized traffic.
        for (int k = 0; k < 400; k++)
            cycle(4'($urandom), $urandom, 16'($urandom));
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
